// File: rtl/seg7_scan_ctrl.sv
// Multi-channel seven-segment scan controller.
// Selects a hex source and snapshots it once per scan frame so a digit never
// mixes two values. Common-anode digits are time-multiplexed, with leading-zero
// suppression, per-digit decimal points and per-digit blink. Channel 0 is a
// CPU-written latch.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int CHANNELS     = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  localparam int W           = 4 * DIGITS,
  localparam int SW          = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [W-1:0]          wdata,
  input  logic [SW-1:0]         ch_sel,
  input  logic [CHANNELS*W-1:0] ch_data,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blink_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [W-1:0]      ch0_q, ch0_d;
  logic [W-1:0]      snap_q, snap_d;
  logic [DIGITS-1:0] dp_f_q, dp_f_d;
  logic [DIGITS-1:0] blink_f_q, blink_f_d;
  logic              lz_f_q, lz_f_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [W-1:0]      src;
  logic              wrap;
  logic              frame_start;
  logic              blank;

  // Per-digit nibble view of the snapshot, and "this nibble and all above are zero".
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] zero_from;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi]       = snap_q[4*gi +: 4];
      assign zero_from[gi] = ~|snap_q[W-1:4*gi];
    end
  endgenerate

  // Source mux: channel 0 is the CPU latch, out-of-range selects read as zero.
  always_comb begin
    src = '0;
    for (int k = 1; k < CHANNELS; k++) begin
      if (ch_sel == SW'(k)) src = ch_data[k*W +: W];
    end
    if (ch_sel == '0) src = ch0_q;
  end

  // Scan timing, CPU latch and per-frame sampling of data and display controls.
  always_comb begin
    wrap        = (presc_q == PW'(SCAN_DIV - 1));
    frame_start = wrap && (digit_q == DW'(DIGITS - 1));
    presc_d     = wrap ? '0 : presc_q + PW'(1);
    digit_d     = digit_q;
    ch0_d       = ch0_q;
    snap_d      = snap_q;
    dp_f_d      = dp_f_q;
    blink_f_d   = blink_f_q;
    lz_f_d      = lz_f_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    if (we) ch0_d = wdata;
    if (wrap) digit_d = frame_start ? '0 : digit_q + DW'(1);
    if (frame_start) begin
      snap_d    = src;
      dp_f_d    = dp_i;
      blink_f_d = blink_i;
      lz_f_d    = lz_en;
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  // Segment/anode pattern for the digit currently selected; registered below.
  always_comb begin
    blank = lz_f_q && (digit_q != '0) && zero_from[digit_q];
    seg_d = {~dp_f_q[digit_q], blank ? 7'h7F : hex7(nib[digit_q])};
    an_d  = '1;
    if (!(blink_f_q[digit_q] && phase_q)) an_d[digit_q] = 1'b0;
  end

  // State and output registers; everything clears the instant rstn drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q   <= '0;
      digit_q   <= '0;
      ch0_q     <= '0;
      snap_q    <= '0;
      dp_f_q    <= '0;
      blink_f_q <= '0;
      lz_f_q    <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      ch0_q     <= ch0_d;
      snap_q    <= snap_d;
      dp_f_q    <= dp_f_d;
      blink_f_q <= blink_f_d;
      lz_f_q    <= lz_f_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised bench for seg7_scan_ctrl against a cycle-count based display model.
module tb_seg7_scan_ctrl;

  localparam int DIGITS       = 8;
  localparam int CHANNELS     = 10;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int W            = 4 * DIGITS;
  localparam int SW           = 4;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic                  clk;
  logic                  rstn;
  logic                  we;
  logic [W-1:0]          wdata;
  logic [SW-1:0]         ch_sel;
  logic [CHANNELS*W-1:0] ch_data;
  logic                  lz_en;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     blink_i;
  logic [7:0]            seg_o;
  logic [DIGITS-1:0]     an_o;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .CHANNELS(CHANNELS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rstn(rstn), .we(we), .wdata(wdata), .ch_sel(ch_sel), .ch_data(ch_data),
    .lz_en(lz_en), .dp_i(dp_i), .blink_i(blink_i), .seg_o(seg_o), .an_o(an_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: n = clock edges since reset release; cur_* = values shown this frame.
  int                n;
  logic [W-1:0]      m_ch0;
  logic [W-1:0]      cur_val;
  logic [DIGITS-1:0] cur_dp;
  logic [DIGITS-1:0] cur_blink;
  logic              cur_lz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    n         = 0;
    m_ch0     = '0;
    cur_val   = '0;
    cur_dp    = '0;
    cur_blink = '0;
    cur_lz    = 1'b0;
  endtask

  function automatic logic [W-1:0] model_src();
    if (ch_sel == 0) return m_ch0;
    if (int'(ch_sel) < CHANNELS) return ch_data[int'(ch_sel)*W +: W];
    return '0;
  endfunction

  // One clock edge: predict what the edge shows, update model, check outputs.
  task automatic tick();
    int                f, d;
    logic              phase, blank;
    logic [3:0]        nibv;
    logic [7:0]        exp_seg;
    logic [DIGITS-1:0] exp_an;
    n++;
    f     = (n - 1) / FRAME;
    d     = ((n - 1) / SCAN_DIV) % DIGITS;
    phase = ((f / BLINK_FRAMES) % 2) == 1;
    nibv  = 4'((cur_val >> (4 * d)) & 32'hF);
    blank = cur_lz && (d > 0) && ((cur_val >> (4 * d)) == 0);
    exp_seg = {~cur_dp[d], blank ? 7'h7F : hex_tab[nibv]};
    exp_an  = '1;
    if (!(cur_blink[d] && phase)) exp_an[d] = 1'b0;
    if (n % FRAME == 0) begin
      cur_val   = model_src();
      cur_dp    = dp_i;
      cur_blink = blink_i;
      cur_lz    = lz_en;
      $display("frame %0d: val=%h dp=%h blink=%h lz=%0d", n / FRAME, cur_val, cur_dp, cur_blink, cur_lz);
    end
    if (we) m_ch0 = wdata;
    @(posedge clk);
    #1;
    chk("seg", seg_o, exp_seg);
    chk("an", an_o, exp_an);
  endtask

  task automatic run_frames(input int k);
    repeat (k * FRAME) tick();
  endtask

  // Advance so that the next tick lands on a frame-start edge.
  task automatic to_frame_edge();
    while ((n + 1) % FRAME != 0) tick();
  endtask

  initial begin
    rstn = 1'b0; we = 1'b0; wdata = '0; ch_sel = '0; ch_data = '0;
    lz_en = 1'b0; dp_i = '0; blink_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_an", an_o, 8'hFF);
    @(negedge clk);
    rstn = 1'b1;

    // CPU write to channel 0, visible from the next frame.
    we = 1'b1; wdata = 32'h1234_5678;
    tick();
    chk("first_seg", seg_o, 8'hC0);
    chk("first_an", an_o, 8'hFE);
    we = 1'b0;
    run_frames(2);

    // Leading-zero suppression on a live channel, then an out-of-range select.
    lz_en = 1'b1;
    ch_data[3*W +: W] = 32'h0000_00A0;
    ch_sel = 4'd3;
    run_frames(2);
    ch_sel = 4'd9;
    run_frames(2);

    // Write landing exactly on a frame-start edge.
    lz_en = 1'b0; ch_sel = 4'd0;
    we = 1'b1; wdata = '0;
    tick();
    we = 1'b0;
    to_frame_edge();
    we = 1'b1; wdata = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    run_frames(2);

    // Blink on digit 0.
    blink_i = 8'h01;
    run_frames(6);
    blink_i = 8'h00;

    // Decimal point on a blanked digit.
    dp_i = 8'h80; lz_en = 1'b1; ch_sel = 4'd9;
    run_frames(2);

    // Random mid-frame changes; all must only take effect at frame starts.
    repeat (800) begin
      we = 1'b0;
      if ($urandom_range(0, 7) == 0) ch_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < CHANNELS; k++)
          ch_data[k*W +: W] = 32'($urandom) >> (4 * $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) begin
        we    = 1'b1;
        wdata = 32'($urandom) >> (4 * $urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 15) == 0) dp_i = 8'($urandom);
      if ($urandom_range(0, 15) == 0) blink_i = 8'($urandom);
      tick();
    end
    we = 1'b0;

    // Asynchronous reset in the middle of digit 3.
    while (!((((n - 1) / SCAN_DIV) % DIGITS == 3) && ((n - 1) % SCAN_DIV == 1))) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_seg", seg_o, 8'hFF);
    chk("async_an", an_o, 8'hFF);
    @(negedge clk);
    chk("hold_seg", seg_o, 8'hFF);
    rstn = 1'b1;
    model_reset();
    tick();
    chk("restart_seg", seg_o, 8'hC0);
    chk("restart_an", an_o, 8'hFE);
    run_frames(1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
